// File: rtl/vlane_iter_divider.sv
// Per-lane radix-2 restoring divider for vdiv/vdivu/vrem/vremu on one element.
// Special cases (divide by zero, signed overflow) finish in a single cycle.
module vlane_iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start_div,
  input  logic [WIDTH-1:0] vs2_data,
  input  logic [WIDTH-1:0] vs1_data,
  input  logic             div_type,
  input  logic             is_signed_div,
  input  logic [1:0]       sew,
  input  logic             flush,
  output logic [WIDTH-1:0] wdata_du,
  output logic             busy_du,
  output logic             done_du,
  output logic             exception_du
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic [WIDTH-1:0] ext_sew(input logic [WIDTH-1:0] v,
                                               input logic [1:0] s,
                                               input logic sgn);
    logic [WIDTH-1:0] r;
    case (s)
      2'b00:   r = sgn ? {{(WIDTH-8){v[7]}}, v[7:0]}   : {{(WIDTH-8){1'b0}}, v[7:0]};
      2'b01:   r = sgn ? {{(WIDTH-16){v[15]}}, v[15:0]} : {{(WIDTH-16){1'b0}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Dividend magnitude is left-aligned so its next bit is always the register MSB.
  function automatic logic [WIDTH-1:0] align_sew(input logic [WIDTH-1:0] v,
                                                 input logic [1:0] s);
    logic [WIDTH-1:0] r;
    case (s)
      2'b00:   r = {v[7:0], {(WIDTH-8){1'b0}}};
      2'b01:   r = {v[15:0], {(WIDTH-16){1'b0}}};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] min_sew(input logic [1:0] s);
    logic [WIDTH-1:0] r;
    case (s)
      2'b00:   r = {{(WIDTH-7){1'b1}}, 7'b0000000};
      2'b01:   r = {{(WIDTH-15){1'b1}}, 15'b000000000000000};
      default: r = {1'b1, {(WIDTH-1){1'b0}}};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sew_count(input logic [1:0] s);
    logic [CNT_W-1:0] r;
    case (s)
      2'b00:   r = CNT_W'(8);
      2'b01:   r = CNT_W'(16);
      default: r = CNT_W'(WIDTH);
    endcase
    return r;
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             type_q;
  logic             sgn_q;
  logic [1:0]       sew_q;
  logic [WIDTH-1:0] wdata_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       sew_eff_s;
  logic [WIDTH-1:0] a_ext_s;
  logic [WIDTH-1:0] b_ext_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             special_s;
  logic [WIDTH-1:0] special_res_s;

  // Operand preparation and special-case detection for an accepted start.
  always_comb begin
    sew_eff_s     = (sew == 2'b11) ? 2'b10 : sew;
    a_ext_s       = ext_sew(vs2_data, sew_eff_s, is_signed_div);
    b_ext_s       = ext_sew(vs1_data, sew_eff_s, is_signed_div);
    a_neg_s       = is_signed_div & a_ext_s[WIDTH-1];
    b_neg_s       = is_signed_div & b_ext_s[WIDTH-1];
    a_mag_s       = a_neg_s ? (~a_ext_s + {{(WIDTH-1){1'b0}}, 1'b1}) : a_ext_s;
    b_mag_s       = b_neg_s ? (~b_ext_s + {{(WIDTH-1){1'b0}}, 1'b1}) : b_ext_s;
    special_s     = 1'b0;
    special_res_s = {WIDTH{1'b0}};
    if (b_ext_s == {WIDTH{1'b0}}) begin
      special_s     = 1'b1;
      special_res_s = div_type ? a_ext_s : ext_sew({WIDTH{1'b1}}, sew_eff_s, is_signed_div);
    end else if (is_signed_div && (a_ext_s == min_sew(sew_eff_s)) &&
                 (b_ext_s == {WIDTH{1'b1}})) begin
      special_s     = 1'b1;
      special_res_s = div_type ? {WIDTH{1'b0}} : a_ext_s;
    end else begin
      special_s     = 1'b0;
      special_res_s = {WIDTH{1'b0}};
    end
  end

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic [WIDTH-1:0] calc_res_s;

  // One restoring step plus the sign fixup used on the final step.
  always_comb begin
    shift_s    = {rem_q, dvd_q[WIDTH-1]};
    diff_s     = shift_s - {1'b0, dvs_q};
    qbit_s     = (shift_s >= {1'b0, dvs_q});
    rem_d      = WIDTH'(qbit_s ? diff_s : shift_s);
    dvd_d      = {dvd_q[WIDTH-2:0], qbit_s};
    q_fix_s    = qneg_q ? (~dvd_d + {{(WIDTH-1){1'b0}}, 1'b1}) : dvd_d;
    r_fix_s    = rneg_q ? (~rem_d + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_d;
    calc_res_s = ext_sew(type_q ? r_fix_s : q_fix_s, sew_q, sgn_q);
  end

  // Control FSM with datapath registers; flush overrides any start request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      type_q  <= 1'b0;
      sgn_q   <= 1'b0;
      sew_q   <= 2'b00;
      wdata_q <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_div) begin
            type_q <= div_type;
            sgn_q  <= is_signed_div;
            sew_q  <= sew_eff_s;
            if (special_s) begin
              state_q <= S_DONE;
              wdata_q <= special_res_s;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
              cnt_q   <= sew_count(sew_eff_s);
              rem_q   <= {WIDTH{1'b0}};
              dvd_q   <= align_sew(a_mag_s, sew_eff_s);
              dvs_q   <= b_mag_s;
              qneg_q  <= a_neg_s ^ b_neg_s;
              rneg_q  <= a_neg_s;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == CNT_W'(1'b1)) begin
            state_q <= S_DONE;
            wdata_q <= calc_res_s;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1'b1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wdata_du     = wdata_q;
  assign busy_du      = busy_q;
  assign done_du      = done_q;
  assign exception_du = 1'b0;

endmodule

// File: tb/tb_vlane_iter_divider.sv
// Directed self-checking bench for vlane_iter_divider: latency, results,
// special cases, flush, back-to-back issue and asynchronous reset.
module tb_vlane_iter_divider;

  logic        CLK;
  logic        nRST;
  logic        start_div;
  logic [31:0] vs2_data;
  logic [31:0] vs1_data;
  logic        div_type;
  logic        is_signed_div;
  logic [1:0]  sew;
  logic        flush;
  logic [31:0] wdata_du;
  logic        busy_du;
  logic        done_du;
  logic        exception_du;

  int pass_cnt = 0;
  int total_cnt = 0;

  vlane_iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .nRST(nRST), .start_div(start_div), .vs2_data(vs2_data),
    .vs1_data(vs1_data), .div_type(div_type), .is_signed_div(is_signed_div),
    .sew(sew), .flush(flush), .wdata_du(wdata_du), .busy_du(busy_du),
    .done_du(done_du), .exception_du(exception_du)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic t,
                       input logic sg, input logic [1:0] w);
    vs2_data = a; vs1_data = b; div_type = t; is_signed_div = sg; sew = w;
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
  endtask

  // n = cycle index (1 = cycle after the accepting edge) at which done_du is seen.
  task automatic wait_done(output int n, output int bc);
    n = 1; bc = 0;
    while (done_du !== 1'b1 && n < 100) begin
      if (busy_du === 1'b1) bc++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; start_div = 1'b0; flush = 1'b0;
    vs2_data = 32'h0; vs1_data = 32'h0; div_type = 1'b0; is_signed_div = 1'b0; sew = 2'b10;
    repeat (3) tick();
    total_cnt++; if (wdata_du !== 32'h0) $display("FAIL reset_wdata got %h want 00000000", wdata_du); else pass_cnt++;
    total_cnt++; if (busy_du !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_du); else pass_cnt++;
    total_cnt++; if (done_du !== 1'b0) $display("FAIL reset_done got %b want 0", done_du); else pass_cnt++;
    total_cnt++; if (exception_du !== 1'b0) $display("FAIL reset_exc got %b want 0", exception_du); else pass_cnt++;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_signed32();
    int n, bc;
    issue(32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b1, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (n != 33) $display("FAIL s32_q_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (bc != 32) $display("FAIL s32_busy_cycles got %0d want 32", bc); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'hFFFFFFFD) $display("FAIL s32_quot got %h want FFFFFFFD", wdata_du); else pass_cnt++;
    tick();
    total_cnt++; if (done_du !== 1'b0) $display("FAIL s32_done_pulse got %b want 0", done_du); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'hFFFFFFFD) $display("FAIL s32_hold got %h want FFFFFFFD", wdata_du); else pass_cnt++;
    issue(32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (n != 33) $display("FAIL s32_r_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'hFFFFFFFF) $display("FAIL s32_rem got %h want FFFFFFFF", wdata_du); else pass_cnt++;
    tick();
  endtask

  task automatic test_unsigned8();
    int n, bc;
    issue(32'h000000C8, 32'h00000007, 1'b0, 1'b0, 2'b00);
    wait_done(n, bc);
    total_cnt++; if (n != 9) $display("FAIL u8_latency got %0d want 9", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h0000001C) $display("FAIL u8_quot got %h want 0000001C", wdata_du); else pass_cnt++;
    tick();
    issue(32'h000000C8, 32'h00000007, 1'b1, 1'b0, 2'b00);
    wait_done(n, bc);
    total_cnt++; if (wdata_du !== 32'h00000004) $display("FAIL u8_rem got %h want 00000004", wdata_du); else pass_cnt++;
    tick();
  endtask

  task automatic test_div_zero();
    int n, bc;
    issue(32'h12345678, 32'h00000000, 1'b0, 1'b0, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (n != 1) $display("FAIL dz_latency got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'hFFFFFFFF) $display("FAIL dz_quot got %h want FFFFFFFF", wdata_du); else pass_cnt++;
    tick();
    total_cnt++; if (bc != 0 || busy_du !== 1'b0) $display("FAIL dz_busy got cnt=%0d busy=%b want 0", bc, busy_du); else pass_cnt++;
    issue(32'h12345678, 32'h00000000, 1'b1, 1'b0, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (wdata_du !== 32'h12345678) $display("FAIL dz_rem got %h want 12345678", wdata_du); else pass_cnt++;
    tick();
    issue(32'h000000AB, 32'hFFFFFF00, 1'b0, 1'b0, 2'b00);
    wait_done(n, bc);
    total_cnt++; if (wdata_du !== 32'h000000FF) $display("FAIL dz_u8_quot got %h want 000000FF", wdata_du); else pass_cnt++;
    tick();
  endtask

  task automatic test_overflow();
    int n, bc;
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (n != 1) $display("FAIL ovf32_latency got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h80000000) $display("FAIL ovf32_quot got %h want 80000000", wdata_du); else pass_cnt++;
    tick();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (wdata_du !== 32'h00000000) $display("FAIL ovf32_rem got %h want 00000000", wdata_du); else pass_cnt++;
    tick();
    issue(32'h12348000, 32'h0000FFFF, 1'b0, 1'b1, 2'b01);
    wait_done(n, bc);
    total_cnt++; if (wdata_du !== 32'hFFFF8000) $display("FAIL ovf16_quot got %h want FFFF8000", wdata_du); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    int n, bc;
    logic seen_done;
    issue(32'h0000005A, 32'h00000000, 1'b1, 1'b0, 2'b00);
    wait_done(n, bc);
    total_cnt++; if (wdata_du !== 32'h0000005A) $display("FAIL fl_pre got %h want 0000005A", wdata_du); else pass_cnt++;
    tick();
    issue(32'h7FFFFFFF, 32'h00000005, 1'b0, 1'b0, 2'b10);
    seen_done = done_du;
    repeat (4) begin
      tick();
      seen_done = seen_done | done_du;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen_done = seen_done | done_du;
    total_cnt++; if (busy_du !== 1'b0) $display("FAIL fl_busy got %b want 0", busy_du); else pass_cnt++;
    tick();
    seen_done = seen_done | done_du;
    total_cnt++; if (seen_done !== 1'b0) $display("FAIL fl_no_done got %b want 0", seen_done); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h0000005A) $display("FAIL fl_wdata got %h want 0000005A", wdata_du); else pass_cnt++;
    issue(32'h00000064, 32'hFFFFFFFD, 1'b0, 1'b1, 2'b10);
    wait_done(n, bc);
    total_cnt++; if (n != 33) $display("FAIL fl_restart_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'hFFFFFFDF) $display("FAIL fl_restart_quot got %h want FFFFFFDF", wdata_du); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int n, bc;
    vs2_data = 32'd1000; vs1_data = 32'd10; div_type = 1'b0; is_signed_div = 1'b0; sew = 2'b10;
    start_div = 1'b1;
    tick();
    vs2_data = 32'hFFFFFFFF; vs1_data = 32'h00000010; div_type = 1'b1;
    wait_done(n, bc);
    total_cnt++; if (n != 33) $display("FAIL b2b_first_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h00000064) $display("FAIL b2b_first got %h want 00000064", wdata_du); else pass_cnt++;
    tick();
    start_div = 1'b0;
    wait_done(n, bc);
    total_cnt++; if (n != 33) $display("FAIL b2b_spacing got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h0000000F) $display("FAIL b2b_second got %h want 0000000F", wdata_du); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int n, bc;
    issue(32'h7FFFFFFF, 32'h00000003, 1'b0, 1'b0, 2'b10);
    repeat (5) tick();
    #1 nRST = 1'b0;
    #1;
    total_cnt++; if (busy_du !== 1'b0) $display("FAIL rm_busy got %b want 0", busy_du); else pass_cnt++;
    total_cnt++; if (done_du !== 1'b0) $display("FAIL rm_done got %b want 0", done_du); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h0) $display("FAIL rm_wdata got %h want 00000000", wdata_du); else pass_cnt++;
    #1 nRST = 1'b1;
    issue(32'h000000C8, 32'h00000007, 1'b0, 1'b0, 2'b00);
    wait_done(n, bc);
    total_cnt++; if (n != 9) $display("FAIL rm_after_latency got %0d want 9", n); else pass_cnt++;
    total_cnt++; if (wdata_du !== 32'h0000001C) $display("FAIL rm_after_quot got %h want 0000001C", wdata_du); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_signed32();
    test_unsigned8();
    test_div_zero();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vlane_iter_divider.md
Name: vlane_iter_divider

Overview:
Per-lane iterative integer divider for the vector lane, implementing vdiv/vdivu/vrem/vremu on one element per operation.
- Consumes the lane's divide-unit signals: vs1_data, vs2_data, start_div, div_type, is_signed_div, sew.
- Produces wdata_du, busy_du, done_du and exception_du for the lane result mux.
- Radix-2 restoring division on operand magnitudes, with a sign fixup and single-cycle fast paths for RVV special cases.

Parameters:
- WIDTH, 32, lane datapath width in bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- start_div  input  1  start request, sampled only in IDLE.
- vs2_data  input  32  dividend; low SEW bits used.
- vs1_data  input  32  divisor; low SEW bits used.
- div_type  input  1  result select: 0 = quotient, 1 = remainder.
- is_signed_div  input  1  1 = signed (vdiv/vrem), 0 = unsigned.
- sew  input  2  element width: 00 = 8, 01 = 16, 10 = 32; 11 is reserved and treated as 32.
- flush  input  1  abort the in-flight operation.
- wdata_du  output  32  result; valid while done_du = 1 and held until the next accepted start.
- busy_du  output  1  operation in flight.
- done_du  output  1  single-cycle completion pulse.
- exception_du  output  1  always 0; RVV divide never traps.

Behaviour:
Reset:
- Async on nRST low: state = IDLE; wdata_du, busy_du and done_du = 0; all internal registers cleared.
- This applies mid-operation too; no done_du is produced for the aborted element.

FSM states: IDLE, CALC, DONE.
- IDLE: if start_div = 1, latch operands, div_type, is_signed_div and sew.
  - Special case: go to DONE.
  - Otherwise: go to CALC with counter = SEW.
- CALC: one quotient bit per cycle; counter decrements; when counter reaches 1, go to DONE.
- DONE: done_du = 1 for exactly one cycle. If start_div = 1 in this cycle, it is accepted as if in IDLE (back-to-back issue); otherwise go to IDLE.

Outputs:
- busy_du = 1 in CALC, else 0. It is registered, so it rises the cycle after start is accepted.
- start_div while in CALC is ignored.

Latency (start sampled at edge 0; done_du high in cycle N):
- Normal path: N = SEW + 1, i.e. 9, 17 or 33 for SEW 8, 16, 32.
- Special cases: N = 1.

Operand preparation:
- Take the low SEW bits.
- Signed: sign-extend from bit SEW-1, then take magnitudes.
- Unsigned: zero-extend.

Arithmetic (per CALC cycle, SEW-bit datapath):
- rem = {rem, dividend_msb} - divisor.
- If non-negative: keep the difference and shift in quotient bit 1.
- Otherwise: restore and shift in 0.

Sign fixup on the CALC->DONE transition:
- Quotient is negated if the operand signs differ (signed only).
- Remainder takes the dividend's sign.

Special cases, evaluated in IDLE, with no CALC cycles:
- Divisor = 0: quotient = all ones (SEW-wide); remainder = dividend.
- Signed overflow (dividend = most-negative SEW value, divisor = -1): quotient = dividend; remainder = 0.

Result width:
- SEW-bit result extended to 32 bits: sign-extended when is_signed_div = 1, zero-extended otherwise.

Flush:
- flush = 1 in any state: next state IDLE, busy_du = 0, no done_du.
- flush has priority over start_div in the same cycle.
- wdata_du keeps its previous value.

Test Plan:
- SEW = 32, signed, vs2 = 0xFFFFFFF9 (-7), vs1 = 0x00000002: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; done_du in cycle 33; busy_du high cycles 1–32.
- SEW = 8, unsigned, vs2 = 0x000000C8 (200), vs1 = 0x00000007: quotient 0x0000001C, remainder 0x00000004; done_du in cycle 9.
- Divide by zero, SEW = 32, vs2 = 0x12345678, vs1 = 0: quotient 0xFFFFFFFF, remainder 0x12345678; done_du in cycle 1; busy_du never rises.
- Signed overflow:
  - SEW = 32, vs2 = 0x80000000, vs1 = 0xFFFFFFFF: quotient 0x80000000, remainder 0; done_du in cycle 1.
  - SEW = 16, vs2 = 0x12348000, vs1 = 0x0000FFFF: quotient 0xFFFF8000.
- flush at cycle 5 of a SEW = 32 divide: IDLE at cycle 6, no done_du, wdata_du unchanged. A fresh start at cycle 7 completes normally at cycle 40.
- Back-to-back: start held high through DONE, second op accepted with done_du spacing 33 cycles. nRST asserted mid-CALC: all outputs 0 immediately; next start behaves as from reset.
